// File: rtl/systolic_result_drain_if.sv
// Output beat bus of the systolic result drain.
//   m_valid / m_ready : valid/ready handshake, beat transfers when both high
//   m_data            : raw signed result element
//   m_pixel           : scaled, clamped 8-bit pixel of m_data
//   m_row / m_col     : matrix coordinates of the current beat
//   m_last            : marks the final element (N-1, N-1) of a frame
interface systolic_result_drain_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;
  logic [7:0]               m_pixel;
  logic [IDX_W-1:0]         m_row;
  logic [IDX_W-1:0]         m_col;
  logic                     m_last;

  modport master (
    output m_valid, m_data, m_pixel, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_pixel, m_row, m_col, m_last,
    output m_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Output-side reader for the weight-stationary systolic array.
// Detects the rising edge of the array's done strobe, snapshots the N x N
// signed result matrix after CAPTURE_DELAY cycles, then streams it row-major,
// one element per valid/ready handshake, with a scaled 8-bit pixel per beat.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   arr_done_i      : done level from the array
//   arr_result_i    : parallel result matrix [row][col]
//   m               : beat bus (master side)
//   busy            : high whenever the FSM is not idle
//   overrun         : sticky, a new result arrived mid-stream and was dropped
//   clear_overrun   : synchronous clear of overrun (a same-cycle set wins)
module systolic_result_drain #(
  parameter int N             = 10,
  parameter int DATA_W        = 16,
  parameter int SHIFT         = 7,
  parameter int CAPTURE_DELAY = 1,
  parameter int IDX_W         = $clog2(N)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arr_done_i,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]    arr_result_i,
  systolic_result_drain_if.master            m,
  output logic                               busy,
  output logic                               overrun,
  input  logic                               clear_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [1:0]       CNT_LOAD = 2'((CAPTURE_DELAY == 0) ? 0 : CAPTURE_DELAY - 1);

  state_t                          state_q, state_d;
  logic                            done_q;
  logic [1:0]                      cnt_q, cnt_d;
  logic [IDX_W-1:0]                row_q, row_d;
  logic [IDX_W-1:0]                col_q, col_d;
  logic                            overrun_q, overrun_d;
  logic [N-1:0][N-1:0][DATA_W-1:0] snap_q, snap_d;

  logic                     rise;
  logic                     valid;
  logic                     fire;
  logic                     at_last;
  logic                     capture;
  logic                     start_frame;
  logic                     overrun_set;
  logic signed [DATA_W-1:0] elem;
  logic signed [DATA_W-1:0] shifted;
  logic [7:0]               pixel;

  assign rise    = arr_done_i && !done_q;
  assign valid   = (state_q == S_STREAM);
  assign fire    = valid && m.m_ready;
  assign at_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    capture     = 1'b0;
    start_frame = 1'b0;
    overrun_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        start_frame = rise;
      end
      S_WAIT: begin
        // Edges seen while waiting belong to the frame already being captured.
        if (cnt_q == 2'd0) begin
          capture = 1'b1;
          state_d = S_STREAM;
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_STREAM: begin
        if (fire) begin
          if (at_last) begin
            row_d       = '0;
            col_d       = '0;
            state_d     = S_IDLE;
            // An edge coinciding with the final transfer starts the next frame.
            start_frame = rise;
          end else if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        overrun_set = rise && !(fire && at_last);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_frame) begin
      row_d = '0;
      col_d = '0;
      if (CAPTURE_DELAY == 0) begin
        capture = 1'b1;
        state_d = S_STREAM;
      end else begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
    end
  end

  always_comb begin
    snap_d    = capture ? arr_result_i : snap_q;
    overrun_d = overrun_set || (overrun_q && !clear_overrun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= arr_done_i;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
      snap_q    <= snap_d;
    end
  end

  // Pixel: arithmetic shift keeps the sign so negatives clamp to 0.
  always_comb begin
    elem    = $signed(snap_q[row_q][col_q]);
    shifted = elem >>> SHIFT;
    if (shifted[DATA_W-1]) begin
      pixel = 8'd0;
    end else if (shifted > $signed(DATA_W'(255))) begin
      pixel = 8'd255;
    end else begin
      pixel = shifted[7:0];
    end
  end

  assign m.m_valid = valid;
  assign m.m_data  = elem;
  assign m.m_pixel = pixel;
  assign m.m_row   = row_q;
  assign m.m_col   = col_q;
  assign m.m_last  = valid && at_last;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  logic clr = 1'b0;
  logic busy;
  logic overrun;
  logic [N-1:0][N-1:0][DW-1:0] mat;

  systolic_result_drain_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  systolic_result_drain #(
    .N(N), .DATA_W(DW), .SHIFT(7), .CAPTURE_DELAY(1), .IDX_W(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arr_done_i(done),
    .arr_result_i(mat),
    .m(bus),
    .busy(busy),
    .overrun(overrun),
    .clear_overrun(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] data;
    logic [7:0]           pix;
    logic [IW-1:0]        row;
    logic [IW-1:0]        col;
    logic                 last;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int beats  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_model(input logic [DW-1:0] raw);
    int v;
    v = int'($signed(raw));
    v = v / 128 - ((v < 0 && (v % 128) != 0) ? 1 : 0);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic push_frame();
    beat_t b;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        b.data = mat[r][c];
        b.pix  = pix_model(mat[r][c]);
        b.row  = IW'(r);
        b.col  = IW'(c);
        b.last = (r == N - 1) && (c == N - 1);
        sb.push_back(b);
      end
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = DW'(100 * r + c);
  endtask

  // Monitor: scoreboard pop on each transfer, plus hold-stable check on stalls.
  logic                 pv, pr, plast;
  logic signed [DW-1:0] pd;
  logic [7:0]           ppix;
  logic [IW-1:0]        prow, pcol;
  beat_t                e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_data", 32'(bus.m_data), 32'(pd));
        chk("stall_pixel", 32'(bus.m_pixel), 32'(ppix));
        chk("stall_row", 32'(bus.m_row), 32'(prow));
        chk("stall_col", 32'(bus.m_col), 32'(pcol));
        chk("stall_last", 32'(bus.m_last), 32'(plast));
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("queue_underflow", 32'(sb.size() == 0), 32'd0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("beat_data", 32'(bus.m_data), 32'(e.data));
          chk("beat_pixel", 32'(bus.m_pixel), 32'(e.pix));
          chk("beat_row", 32'(bus.m_row), 32'(e.row));
          chk("beat_col", 32'(bus.m_col), 32'(e.col));
          chk("beat_last", 32'(bus.m_last), 32'(e.last));
          beats++;
        end
      end
      pv    = bus.m_valid;
      pr    = bus.m_ready;
      pd    = bus.m_data;
      ppix  = bus.m_pixel;
      prow  = bus.m_row;
      pcol  = bus.m_col;
      plast = bus.m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_beats(input string tag, input int target);
    int n = 0;
    while (beats < target && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_reached"}, 32'(beats >= target), 32'd1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  localparam int T3N = 8;
  int       t3_val [T3N] = '{-300, 0, 128, 32767, -32768, 32640, 127, 12345};
  logic [7:0] t3_pix [4] = '{8'd0, 8'd0, 8'd1, 8'd255};

  initial begin
    bus.m_ready = 1'b1;
    fill_ramp();

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_pixel", 32'(bus.m_pixel), 32'd0);
    chk("rst_row", 32'(bus.m_row), 32'd0);
    chk("rst_col", 32'(bus.m_col), 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: ramp matrix, ready high, done held 2 cycles, latency and throughput
    beats = 0;
    push_frame();
    done = 1'b1;
    tick();
    chk("t1_wait_valid", 32'(bus.m_valid), 32'd0);
    chk("t1_wait_busy", 32'(busy), 32'd1);
    tick();
    done = 1'b0;
    chk("t1_first_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_first_row", 32'(bus.m_row), 32'd0);
    chk("t1_first_col", 32'(bus.m_col), 32'd0);
    chk("t1_first_last", 32'(bus.m_last), 32'd0);
    repeat (99) tick();
    chk("t1_last_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_last_flag", 32'(bus.m_last), 32'd1);
    chk("t1_last_data", 32'(bus.m_data), 32'd909);
    tick();
    chk("t1_end_valid", 32'(bus.m_valid), 32'd0);
    chk("t1_end_busy", 32'(busy), 32'd0);
    chk("t1_beats", 32'(beats), 32'd100);

    // Test 2: ready pattern 1-0-0-1
    beats = 0;
    push_frame();
    pulse_done();
    for (int k = 0; k < 1000 && (sb.size() != 0 || busy); k++) begin
      bus.m_ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
    end
    bus.m_ready = 1'b1;
    wait_idle("t2");
    chk("t2_beats", 32'(beats), 32'd100);

    // Test 3: pixel clamping with SHIFT = 7
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = DW'(t3_val[(r * N + c) % T3N]);
    beats = 0;
    push_frame();
    pulse_done();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", 32'(bus.m_valid), 32'd1);
      chk("t3_pixel", 32'(bus.m_pixel), 32'(t3_pix[i]));
      chk("t3_raw", 32'(bus.m_data), 32'(t3_val[i]));
      tick();
    end
    wait_idle("t3");

    // Test 4: input changes after the snapshot do not reach the stream
    fill_ramp();
    beats = 0;
    push_frame();
    pulse_done();
    tick();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = 16'h7FFF;
    wait_idle("t4");
    chk("t4_beats", 32'(beats), 32'd100);
    fill_ramp();

    // Test 5: overrun mid-stream, clear, then edge coinciding with last transfer
    beats = 0;
    push_frame();
    pulse_done();
    wait_beats("t5_mid", 50);
    pulse_done();
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    wait_idle("t5a");
    chk("t5_beats", 32'(beats), 32'd100);
    chk("t5_overrun_sticky", 32'(overrun), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_overrun_clr", 32'(overrun), 32'd0);

    beats = 0;
    push_frame();
    pulse_done();
    for (int n = 0; n < 3000 && !(bus.m_valid && bus.m_last); n++) tick();
    chk("t5_last_seen", 32'(bus.m_valid && bus.m_last), 32'd1);
    done = 1'b1;
    push_frame();
    tick();
    done = 1'b0;
    chk("t5_edge_overrun", 32'(overrun), 32'd0);
    chk("t5_edge_busy", 32'(busy), 32'd1);
    chk("t5_edge_valid", 32'(bus.m_valid), 32'd0);
    wait_idle("t5b");
    chk("t5_two_frames", 32'(beats), 32'd200);
    chk("t5_final_overrun", 32'(overrun), 32'd0);

    // Test 6: reset mid-stream, release with done already high
    beats = 0;
    push_frame();
    pulse_done();
    wait_beats("t6_mid", 37);
    chk("t6_pre_valid", 32'(bus.m_valid), 32'd1);
    rst_n = 1'b0;
    done  = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_last", 32'(bus.m_last), 32'd0);
    sb.delete();
    tick();
    tick();
    beats = 0;
    push_frame();
    rst_n = 1'b1;
    tick();
    chk("t6_rel_busy", 32'(busy), 32'd1);
    tick();
    chk("t6_first_valid", 32'(bus.m_valid), 32'd1);
    chk("t6_first_row", 32'(bus.m_row), 32'd0);
    chk("t6_first_col", 32'(bus.m_col), 32'd0);
    done = 1'b0;
    wait_idle("t6");
    chk("t6_beats", 32'(beats), 32'd100);
    chk("t6_overrun", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
